// File: rtl/grid_pkg.sv
// Shared sizes and state encoding for the 8x8 grid scan driver.
package grid_pkg;

  localparam int unsigned ROWS   = 8;
  localparam int unsigned COLS   = 8;
  localparam int unsigned GRID_W = 64;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ROW_ON = 2'd2,
    BLANK  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/scan_timer.sv
// Loadable 8-bit down-counter that times the lit and blanking phases of a row.
module scan_timer
  import grid_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero_c
);

  // Reload on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/grid_scan_driver.sv
// Row-multiplexed LED driver for an 8x8 grid: snapshots a generation once per
// frame, then lights one row at a time with optional blanking between rows.
module grid_scan_driver
  import grid_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [GRID_W-1:0] grid,
  input  logic              grid_valid,
  output logic              grid_ack,
  output logic [ROWS-1:0]   row_sel,
  output logic [COLS-1:0]   col_data,
  output logic              frame_done,
  output logic              busy
);

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD =
    (BLANK_CYCLES != 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);
  // The last phase of a frame is row 7's blanking, or its lit phase when
  // blanking is disabled.
  localparam scan_state_t      FINAL_ST   = (BLANK_CYCLES != 0) ? BLANK : ROW_ON;

  scan_state_t       state, state_nxt;
  logic [ROW_W-1:0]  row, row_nxt;
  logic [GRID_W-1:0] snapshot, snapshot_nxt;
  logic              step_c;
  logic              timer_load;
  logic [CNT_W-1:0]  timer_val;
  logic [CNT_W-1:0]  timer_count;
  logic              timer_zero_c;
  logic              last_nxt;

  logic              grid_ack_nxt;
  logic [ROWS-1:0]   row_sel_nxt;
  logic [COLS-1:0]   col_data_nxt;
  logic              frame_done_nxt;
  logic              busy_nxt;

  scan_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .count    (timer_count),
    .zero_c   (timer_zero_c)
  );

  // State register plus registered outputs, so every output is glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      row        <= '0;
      snapshot   <= '0;
      grid_ack   <= 1'b0;
      row_sel    <= '0;
      col_data   <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      row        <= row_nxt;
      snapshot   <= snapshot_nxt;
      grid_ack   <= grid_ack_nxt;
      row_sel    <= row_sel_nxt;
      col_data   <= col_data_nxt;
      frame_done <= frame_done_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state, row index, snapshot capture and phase timer control.
  always_comb begin
    state_nxt    = state;
    row_nxt      = row;
    snapshot_nxt = snapshot;
    step_c       = 1'b0;
    timer_load   = 1'b0;
    timer_val    = DWELL_LOAD;

    case (state)
      IDLE: begin
        if (enable) state_nxt = LOAD;
      end
      LOAD: begin
        row_nxt    = '0;
        state_nxt  = ROW_ON;
        timer_load = 1'b1;
        timer_val  = DWELL_LOAD;
      end
      ROW_ON: begin
        if (timer_zero_c) begin
          if (BLANK_CYCLES != 0) begin
            state_nxt  = BLANK;
            timer_load = 1'b1;
            timer_val  = BLANK_LOAD;
          end else begin
            step_c = 1'b1;
          end
        end
      end
      BLANK: begin
        if (timer_zero_c) step_c = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // Advance to the next row, or close the frame after row 7.
    if (step_c) begin
      if (row != LAST_ROW) begin
        row_nxt    = row + ROW_W'(1);
        state_nxt  = ROW_ON;
        timer_load = 1'b1;
        timer_val  = DWELL_LOAD;
      end else begin
        state_nxt = enable ? LOAD : IDLE;
      end
    end

    // Only a LOAD entry may update the snapshot, so a frame never tears.
    if (state_nxt == LOAD && grid_valid) snapshot_nxt = grid;

    // True when the upcoming clock is the final one of the current phase.
    last_nxt = timer_load ? (timer_val == '0) : (timer_count == CNT_W'(1));
  end

  // Output decode from the upcoming state, captured by the register above.
  always_comb begin
    grid_ack_nxt   = 1'b0;
    row_sel_nxt    = '0;
    col_data_nxt   = '0;
    frame_done_nxt = 1'b0;
    busy_nxt       = (state_nxt != IDLE);

    if (state_nxt == LOAD && grid_valid) grid_ack_nxt = 1'b1;

    if (state_nxt == ROW_ON) begin
      row_sel_nxt  = ROWS'(1) << row_nxt;
      col_data_nxt = snapshot[{row_nxt, 3'b000} +: COLS];
    end

    if (state_nxt == FINAL_ST && row_nxt == LAST_ROW && last_nxt)
      frame_done_nxt = 1'b1;
  end

endmodule

// File: tb/tb_grid_scan_driver.sv
// Scoreboard bench for grid_scan_driver: default timing instance plus a
// DWELL=1/BLANK=0 instance.
module tb_grid_scan_driver;

  localparam logic [63:0] G1 = 64'h8142241818244281;
  localparam logic [63:0] G2 = 64'h0123456789ABCDEF;

  typedef struct {
    int         kind;  // 0 grid_ack, 1 row start, 2 frame_done
    int         cyc;
    logic [7:0] rs;
    logic [7:0] cd;
  } ev_t;

  typedef struct {
    logic [7:0] rs;
    logic [7:0] cd;
    logic       ack;
    logic       done;
    logic       busy;
  } bexp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [63:0] grid;
  logic        grid_valid;
  logic        grid_ack;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        frame_done;
  logic        busy;

  logic        b_reset;
  logic        b_enable;
  logic [63:0] b_grid;
  logic        b_valid;
  logic        b_ack;
  logic [7:0]  b_rs;
  logic [7:0]  b_cd;
  logic        b_done;
  logic        b_busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc;
  logic [7:0] prev_rs;
  ev_t   sbq[$];
  bexp_t bq[$];

  always #5 clk = ~clk;

  grid_scan_driver u_dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .grid       (grid),
    .grid_valid (grid_valid),
    .grid_ack   (grid_ack),
    .row_sel    (row_sel),
    .col_data   (col_data),
    .frame_done (frame_done),
    .busy       (busy)
  );

  grid_scan_driver #(.DWELL_CYCLES(1), .BLANK_CYCLES(0)) u_fast (
    .clk        (clk),
    .reset      (b_reset),
    .enable     (b_enable),
    .grid       (b_grid),
    .grid_valid (b_valid),
    .grid_ack   (b_ack),
    .row_sel    (b_rs),
    .col_data   (b_cd),
    .frame_done (b_done),
    .busy       (b_busy)
  );

  // Clock edges since the last reset release; edge 1 is the first LOAD.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input int kind, input logic [7:0] rs, input logic [7:0] cd);
    ev_t e;
    if (sbq.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
    end else begin
      e = sbq.pop_front();
      check($sformatf("ev_kind@%0d", e.cyc), 64'(kind), 64'(e.kind));
      check($sformatf("ev_cycle k%0d", e.kind), 64'(cyc), 64'(e.cyc));
      check($sformatf("ev_row_sel@%0d", e.cyc), 64'(rs), 64'(e.rs));
      check($sformatf("ev_col_data@%0d", e.cyc), 64'(cd), 64'(e.cd));
    end
  endtask

  // Expected events of a frame whose LOAD clock is l (DWELL=4, BLANK=1).
  task automatic push_frame(input int l, input logic [63:0] g, input bit ack, input int last_row);
    ev_t e;
    logic [63:0] gv;
    gv = g;
    if (ack) begin
      e.kind = 0; e.cyc = l; e.rs = 8'h00; e.cd = 8'h00;
      sbq.push_back(e);
    end
    for (int r = 0; r <= last_row; r++) begin
      e.kind = 1; e.cyc = l + 1 + 5 * r; e.rs = 8'(1) << r; e.cd = gv[8*r +: 8];
      sbq.push_back(e);
    end
    if (last_row == 7) begin
      e.kind = 2; e.cyc = l + 40; e.rs = 8'h00; e.cd = 8'h00;
      sbq.push_back(e);
    end
  endtask

  task automatic goto_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor for the default instance: invariants every clock, events to scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      prev_rs = 8'h00;
    end else begin
      check("row_sel_onehot", 64'($countones(row_sel) <= 1), 64'd1);
      if (row_sel == 8'h00) check("col_data_dark", 64'(col_data), 64'd0);
      if (grid_ack) sb_pop(0, 8'h00, 8'h00);
      if (row_sel != 8'h00 && row_sel != prev_rs) sb_pop(1, row_sel, col_data);
      if (frame_done) sb_pop(2, 8'h00, 8'h00);
      prev_rs = row_sel;
    end
  end

  // Monitor for the fast instance: one expectation per clock.
  always @(negedge clk) begin
    bexp_t be;
    if (!b_reset && bq.size() > 0) begin
      be = bq.pop_front();
      check("fast_row_sel", 64'(b_rs), 64'(be.rs));
      check("fast_col_data", 64'(b_cd), 64'(be.cd));
      check("fast_ack_done_busy", 64'({b_ack, b_done, b_busy}), 64'({be.ack, be.done, be.busy}));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bexp_t be;
    logic [63:0] g1v;
    reset = 1'b1; enable = 1'b0; grid = '0; grid_valid = 1'b0;
    b_reset = 1'b1; b_enable = 1'b0; b_grid = '0; b_valid = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_row_sel", 64'(row_sel), 64'd0);
    check("rst_col_data", 64'(col_data), 64'd0);
    check("rst_ack_done_busy", 64'({grid_ack, frame_done, busy}), 64'd0);

    // Frame 1 captures G1; frame 2 keeps it despite grid changing without valid.
    enable = 1'b1; grid = G1; grid_valid = 1'b1;
    push_frame(1, G1, 1'b1, 7);
    reset = 1'b0;
    goto_cyc(10);
    grid = 64'hFFFF; grid_valid = 1'b0;
    push_frame(42, G1, 1'b0, 7);

    // New data during frame 2 row 4 must wait for frame 3; held valid acks per LOAD.
    goto_cyc(64);
    grid = G2; grid_valid = 1'b1;
    push_frame(83, G2, 1'b1, 7);
    push_frame(124, G2, 1'b1, 7);

    // Drop enable in frame 4 row 2: frame finishes, then IDLE.
    goto_cyc(136);
    enable = 1'b0;
    goto_cyc(166);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_row_sel", 64'(row_sel), 64'd0);
    check("idle_frame_done", 64'(frame_done), 64'd0);

    // Restart, then reset asynchronously during row 6's lit phase.
    goto_cyc(169);
    enable = 1'b1;
    push_frame(170, G2, 1'b1, 6);
    goto_cyc(202);
    #2 reset = 1'b1;
    #1;
    check("async_row_sel", 64'(row_sel), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_col_data", 64'(col_data), 64'd0);
    check("sb_drained_before_reset", 64'(sbq.size()), 64'd0);
    grid_valid = 1'b0;
    @(negedge clk);

    // Snapshot was cleared by reset, so the restarted frame is dark.
    push_frame(1, 64'h0, 1'b0, 7);
    reset = 1'b0;
    goto_cyc(5);
    enable = 1'b0;
    goto_cyc(44);
    check("restart_idle_busy", 64'(busy), 64'd0);
    check("sb_drained_final", 64'(sbq.size()), 64'd0);

    // Fast instance: DWELL=1, BLANK=0 walks row_sel on consecutive clocks.
    g1v = G1;
    b_enable = 1'b1; b_grid = G1; b_valid = 1'b1;
    be.rs = 8'h00; be.cd = 8'h00; be.ack = 1'b1; be.done = 1'b0; be.busy = 1'b1;
    bq.push_back(be);
    for (int r = 0; r < 8; r++) begin
      be.rs = 8'(1) << r; be.cd = g1v[8*r +: 8]; be.ack = 1'b0;
      be.done = (r == 7); be.busy = 1'b1;
      bq.push_back(be);
    end
    be.rs = 8'h00; be.cd = 8'h00; be.ack = 1'b1; be.done = 1'b0; be.busy = 1'b1;
    bq.push_back(be);
    @(negedge clk);
    #1 b_reset = 1'b0;
    for (int i = 0; i < 20 && bq.size() > 0; i++) @(negedge clk);
    #1;
    check("fast_queue_drained", 64'(bq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_scan_driver.md
GRID_SCAN_DRIVER -- requirements
Module: grid_scan_driver

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 4, clocks each row is lit (legal 1..255).
REQ-002 SHALL have parameter BLANK_CYCLES, default 1, clocks of all-rows-off between rows (legal 0..255).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable  input  1  level; start/continue frame scanning.
REQ-006 SHALL have port grid  input  64  current generation from the grid register; bit 8*r+c = row r, column c.
REQ-007 SHALL have port grid_valid  input  1  level; new generation available for display.
REQ-008 SHALL have port grid_ack  output  1  one-clock pulse; grid captured into snapshot.
REQ-009 SHALL have port row_sel  output  8  one-hot, active-high row drive; bit r = row r.
REQ-010 SHALL have port col_data  output  8  column drive for the lit row; bit c = column c.
REQ-011 SHALL have port frame_done  output  1  one-clock pulse at end of each frame.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, LOAD, ROW_ON, BLANK.
REQ-014 IDLE: row_sel=0, col_data=0; enable=1 -> LOAD on the next clock.
REQ-015 LOAD lasts exactly one clock; if grid_valid=1, snapshot<=grid and grid_ack=1 that clock; otherwise the previous snapshot is kept and grid_ack=0.
REQ-016 LOAD SHALL clear row index to 0 and go to ROW_ON.
REQ-017 ROW_ON: row_sel=1<<row, col_data=snapshot[8*row+7 : 8*row], held for exactly DWELL_CYCLES clocks.
REQ-018 After ROW_ON -> BLANK if BLANK_CYCLES>0 (row_sel=0, col_data=0 for BLANK_CYCLES clocks), else directly to next step.
REQ-019 Next step: row<7 -> row+1, ROW_ON; row=7 -> frame_done=1 for one clock, then LOAD if enable=1 else IDLE.
REQ-020 frame_done SHALL assert on the final clock of row 7's BLANK (or ROW_ON when BLANK_CYCLES=0).
REQ-021 Frame length SHALL be 1 + 8*(DWELL_CYCLES+BLANK_CYCLES) clocks; 41 with defaults.
REQ-022 enable deasserted mid-frame SHALL NOT abort; current frame completes, then IDLE.
REQ-023 grid and grid_valid changes outside LOAD SHALL not affect outputs (no tearing within a frame).
REQ-024 grid_valid held high across frames SHALL be acknowledged once per LOAD.
REQ-025 row_sel SHALL never have more than one bit set; outputs SHALL be registered (glitch-free).
REQ-026 Dwell/blank counter SHALL count down from parameter-1 to 0 and reload on state entry; no wrap beyond parameter.

Reset
REQ-027 Reset SHALL force IDLE, row=0, snapshot=0, row_sel=0, col_data=0, grid_ack=0, frame_done=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock.
REQ-029 After reset release with enable=1, first LOAD SHALL occur on the first clock edge after release.

Structure
REQ-030 grid_pkg SHALL hold ROWS=8, COLS=8, GRID_W=64 and typedef scan_state_t (IDLE, LOAD, ROW_ON, BLANK).
REQ-031 One sub-module scan_timer (8-bit loadable down-counter with zero flag) SHALL time ROW_ON and BLANK.

Verification
REQ-032 Reset, enable=1, grid=64'h8142241818244281, grid_valid=1 -> grid_ack on clock 1; row 0 col_data=8'h81, row 3 col_data=8'h18; frame_done at clock 41.
REQ-033 Frame 2 with grid_valid=0 and grid changed to 64'hFFFF -> snapshot unchanged, grid_ack=0, identical col_data sequence.
REQ-034 Change grid during row 4 of a frame with grid_valid=1 -> rows 5..7 show old snapshot; new data appears from next frame's row 0.
REQ-035 Drop enable during row 2 -> frame completes, frame_done pulses, then IDLE with busy=0, row_sel=0.
REQ-036 BLANK_CYCLES=0, DWELL_CYCLES=1 -> row_sel walks 01,02,...,80 on consecutive clocks; frame length 9.
REQ-037 Assert reset during row 6 ROW_ON -> row_sel=0, busy=0 before the next clock edge; restart begins at LOAD, row 0.
